prime_ram_reader: RTL and testbench

Read-side engine for the prime table RAM. After a go request it fetches the stored primes from the single-port RAM one entry at a time, from address 0 to `count`-1. It presents each value with its address to the seven-segment path for a programmable dwell, then signals completion or wraps for continuous display. It sits between the prime-collection FSM and the display mux, and is active only after the write phase has finished.

---
 rtl/prime_disp_pkg.sv | 22 ++
 rtl/prime_ram_reader_dwell_timer.sv | 49 ++++
 rtl/prime_ram_reader.sv | 127 ++++++++++++
 tb/tb_prime_ram_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prime_disp_pkg.sv
// ---------------------------------------------------------------------------
// prime_disp_pkg
//   Shared definitions for the prime table read/display path.
//   - DEF_ADDR_W / DEF_DATA_W / DEF_DWELL_W : default widths for the RAM
//     address, RAM data and dwell counter.
//   - state_t : state encoding of the read engine FSM.
// ---------------------------------------------------------------------------
package prime_disp_pkg;

   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_DWELL_W = 25;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHOW  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/prime_ram_reader_dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer
//   Counts how long the current entry has been on display.
//   Ports:
//     clk, clr : clock, asynchronous active-high reset
//     load     : capture d as the dwell length (0 is taken as 1)
//     d        : requested dwell length in cycles
//     enable   : count while high; counter is held at 0 while low
//     tc       : high in the cycle the count reaches (dwell length - 1)
// ---------------------------------------------------------------------------
module dwell_timer
   import prime_disp_pkg::*;
#(
   parameter int DWELL_W = DEF_DWELL_W
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               load,
   input  logic [DWELL_W-1:0] d,
   input  logic               enable,
   output logic               tc
);

   localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   logic [DWELL_W-1:0] d_q;
   logic [DWELL_W-1:0] cnt_q;

   // Decoded from registered count and the caller's registered state, so the
   // pulse never depends combinationally on a top-level input.
   assign tc = enable && (cnt_q == (d_q - ONE));

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         d_q   <= '0;
         cnt_q <= '0;
      end else begin
         if (load)
            d_q <= (d == '0) ? ONE : d;
         // Restarting from 0 on tc lets the next entry begin a fresh dwell
         // without any extra clear cycle.
         if (!enable || tc)
            cnt_q <= '0;
         else
            cnt_q <= cnt_q + ONE;
      end
   end

endmodule

// File: rtl/prime_ram_reader.sv
// ---------------------------------------------------------------------------
// prime_ram_reader
//   Walks the prime table RAM from address 0 to count-1, showing each value
//   with its address for a programmable dwell, then pulses done or wraps.
//   Ports:
//     clk, clr          : clock, asynchronous active-high reset
//     start             : begin a pass (honoured in IDLE only)
//     count [ADDR_W:0]  : entries to show, latched at start, clamped to depth
//     loop              : wrap to address 0 after the last entry (live)
//     dwell [DWELL_W]   : cycles per entry, latched at start (0 acts as 1)
//     ram_addr, ram_re  : RAM read request
//     ram_data          : registered RAM read data
//     disp_data/addr    : value and address on display (held between entries)
//     disp_valid        : display fields meaningful (SHOW only)
//     busy              : pass in progress (FETCH/WAIT/SHOW)
//     done              : one-cycle pulse at the end of a non-looping pass
// ---------------------------------------------------------------------------
module prime_ram_reader
   import prime_disp_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int DWELL_W = DEF_DWELL_W
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [ADDR_W:0]    count,
   input  logic               loop,
   input  logic [DWELL_W-1:0] dwell,
   output logic [ADDR_W-1:0]  ram_addr,
   output logic               ram_re,
   input  logic [DATA_W-1:0]  ram_data,
   output logic [DATA_W-1:0]  disp_data,
   output logic [ADDR_W-1:0]  disp_addr,
   output logic               disp_valid,
   output logic               busy,
   output logic               done
);

   localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   N_ONE    = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W:0]   n_q;
   logic [ADDR_W-1:0] addr_q;
   logic              accept;
   logic              last_entry;
   logic              show_tc;

   assign accept     = (state == ST_IDLE) && start;
   assign last_entry = ({1'b0, addr_q} == (n_q - N_ONE));

   dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk    (clk),
      .clr    (clr),
      .load   (accept),
      .d      (dwell),
      .enable (state == ST_SHOW),
      .tc     (show_tc)
   );

   // NOTE: clocked state uses non-blocking (<=) so every register samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is
      // inferred for the branches that stay put.
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            // count==0 is the only way the clamped n can be zero.
            if (start)
               state_nxt = (count == '0) ? ST_DONE : ST_FETCH;
         end
         ST_FETCH: state_nxt = ST_WAIT;
         ST_WAIT:  state_nxt = ST_SHOW;
         ST_SHOW: begin
            if (show_tc)
               state_nxt = (!last_entry || loop) ? ST_FETCH : ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         n_q       <= '0;
         addr_q    <= '0;
         disp_data <= '0;
         disp_addr <= '0;
      end else begin
         if (accept) begin
            n_q    <= (count > DEPTH) ? DEPTH : count;
            addr_q <= '0;
         end else if ((state == ST_SHOW) && show_tc) begin
            // Wrapping to 0 on the last entry serves the loop case; in the
            // non-looping case addr is simply reloaded by the next start.
            addr_q <= last_entry ? '0 : (addr_q + ADDR_ONE);
         end
         // The RAM presents data for the FETCH address by the end of WAIT.
         if (state == ST_WAIT) begin
            disp_data <= ram_data;
            disp_addr <= addr_q;
         end
      end
   end

   // All outputs decode registered state; IDLE (reset) decodes to all zero.
   assign ram_addr   = addr_q;
   assign ram_re     = (state == ST_FETCH);
   assign disp_valid = (state == ST_SHOW);
   assign busy       = (state == ST_FETCH) || (state == ST_WAIT) || (state == ST_SHOW);
   assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_prime_ram_reader.sv
// ---------------------------------------------------------------------------
// tb_prime_ram_reader
//   Directed bench for prime_ram_reader with a registered-read RAM model
//   preloaded with the first 16 primes.
// ---------------------------------------------------------------------------
module tb_prime_ram_reader;

   localparam int ADDR_W  = 4;
   localparam int DATA_W  = 8;
   localparam int DWELL_W = 25;

   logic               clk;
   logic               clr;
   logic               start;
   logic [ADDR_W:0]    count;
   logic               loop;
   logic [DWELL_W-1:0] dwell;
   logic [ADDR_W-1:0]  ram_addr;
   logic               ram_re;
   logic [DATA_W-1:0]  ram_data;
   logic [DATA_W-1:0]  disp_data;
   logic [ADDR_W-1:0]  disp_addr;
   logic               disp_valid;
   logic               busy;
   logic               done;

   int vectors    = 0;
   int miscompares = 0;
   bit re_seen;

   logic [DATA_W-1:0] exp_mem [16] = '{8'd2, 8'd3, 8'd5, 8'd7, 8'd11, 8'd13, 8'd17, 8'd19,
                                       8'd23, 8'd29, 8'd31, 8'd37, 8'd41, 8'd43, 8'd47, 8'd53};

   prime_ram_reader #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk        (clk),
      .clr        (clr),
      .start      (start),
      .count      (count),
      .loop       (loop),
      .dwell      (dwell),
      .ram_addr   (ram_addr),
      .ram_re     (ram_re),
      .ram_data   (ram_data),
      .disp_data  (disp_data),
      .disp_addr  (disp_addr),
      .disp_valid (disp_valid),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM model: registered read, data valid one edge after ram_re.
   initial ram_data = '0;
   always @(posedge clk) begin
      if (ram_re === 1'b1)
         ram_data <= exp_mem[ram_addr];
   end

   always @(posedge clk) begin
      if (ram_re === 1'b1)
         re_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a start for one edge; returns while sampling the first cycle
   // after acceptance.
   task automatic run_start(input int cnt, input int dw, input bit lp);
      count = (ADDR_W+1)'(cnt);
      dwell = DWELL_W'(dw);
      loop  = lp;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Walks one pass of n entries with effective dwell d, starting in the
   // FETCH cycle of entry 0. Optionally drops loop / pulses start at a given
   // cycle, and checks the done pulse at the end.
   task automatic run_pass(input string name, input int n, input int d,
                           input bit expect_done, input int drop_at, input int start_at);
      int e;
      int p;
      bit exp_re;
      bit exp_valid;
      for (int c = 0; c < n * (d + 2); c++) begin
         e = c / (d + 2);
         p = c % (d + 2);
         exp_re    = (p == 0);
         exp_valid = (p >= 2);
         vectors++;
         if (ram_re !== exp_re) begin
            miscompares++;
            $display("FAIL %s c=%0d ram_re got %b want %b", name, c, ram_re, exp_re);
         end
         if (exp_re) begin
            vectors++;
            if (ram_addr !== 4'(e)) begin
               miscompares++;
               $display("FAIL %s c=%0d ram_addr got %0d want %0d", name, c, ram_addr, e);
            end
         end
         vectors++;
         if (busy !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s c=%0d busy/done got %b/%b want 1/0", name, c, busy, done);
         end
         vectors++;
         if (disp_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL %s c=%0d disp_valid got %b want %b", name, c, disp_valid, exp_valid);
         end
         if (exp_valid) begin
            vectors++;
            if (disp_data !== exp_mem[e] || disp_addr !== 4'(e)) begin
               miscompares++;
               $display("FAIL %s c=%0d disp got %0d@%0d want %0d@%0d",
                        name, c, disp_data, disp_addr, exp_mem[e], e);
            end
         end
         if (c == drop_at)
            loop = 1'b0;
         start = (c == start_at);
         tick();
      end
      start = 1'b0;
      if (expect_done) begin
         vectors++;
         if (done !== 1'b1 || busy !== 1'b0 || disp_valid !== 1'b0 || ram_re !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end done/busy/valid/re got %b%b%b%b want 1000",
                     name, done, busy, disp_valid, ram_re);
         end
         vectors++;
         if (disp_data !== exp_mem[n-1] || disp_addr !== 4'(n - 1)) begin
            miscompares++;
            $display("FAIL %s end hold got %0d@%0d want %0d@%0d",
                     name, disp_data, disp_addr, exp_mem[n-1], n - 1);
         end
         tick();
         vectors++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after done/busy got %b/%b want 0/0", name, done, busy);
         end
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (3) tick();
      vectors++;
      if ({ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_held outputs got %h want 0",
                  {ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done});
      end
      clr = 1'b0;
      tick();
      vectors++;
      if ({ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_released outputs got %h want 0",
                  {ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done});
      end
   endtask

   task automatic test_basic();
      run_start(5, 3, 1'b0);
      run_pass("basic", 5, 3, 1'b1, -1, -1);
   endtask

   task automatic test_count_zero();
      re_seen = 1'b0;
      run_start(0, 3, 1'b0);
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0 || ram_re !== 1'b0 || disp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL count_zero done/busy/re/valid got %b%b%b%b want 1000",
                  done, busy, ram_re, disp_valid);
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL count_zero_after done/busy got %b/%b want 0/0", done, busy);
      end
      tick();
      vectors++;
      if (re_seen !== 1'b0) begin
         miscompares++;
         $display("FAIL count_zero_ram_re seen got %b want 0", re_seen);
      end
   endtask

   task automatic test_clamp();
      run_start(20, 1, 1'b0);
      run_pass("clamp", 16, 1, 1'b1, -1, -1);
   endtask

   task automatic test_loop();
      run_start(5, 2, 1'b1);
      run_pass("loop_pass1", 5, 2, 1'b0, -1, -1);
      // Second pass restarts at address 0; loop dropped during entry 2.
      run_pass("loop_pass2", 5, 2, 1'b1, 2 * 4 + 2, -1);
   endtask

   task automatic test_dwell_zero();
      run_start(3, 0, 1'b0);
      // Late changes to count/dwell must not affect the accepted pass.
      count = 5'd1;
      dwell = 25'd7;
      run_pass("dwell_zero", 3, 1, 1'b1, -1, 5);
   endtask

   task automatic test_clr_mid();
      run_start(5, 3, 1'b0);
      repeat (12) tick();
      vectors++;
      if (disp_valid !== 1'b1 || disp_addr !== 4'd2 || disp_data !== 8'd5) begin
         miscompares++;
         $display("FAIL clr_pre valid/addr/data got %b/%0d/%0d want 1/2/5",
                  disp_valid, disp_addr, disp_data);
      end
      #2 clr = 1'b1;
      #1;
      vectors++;
      if ({ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL clr_async outputs got %h want 0",
                  {ram_addr, ram_re, disp_data, disp_addr, disp_valid, busy, done});
      end
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL clr_no_done done/busy got %b/%b want 0/0", done, busy);
      end
      clr = 1'b0;
      tick();
      run_start(5, 3, 1'b0);
      run_pass("after_clr", 5, 3, 1'b1, -1, -1);
   endtask

   initial begin
      clr   = 1'b1;
      start = 1'b0;
      count = '0;
      loop  = 1'b0;
      dwell = '0;
      re_seen = 1'b0;
      test_reset();
      test_basic();
      test_count_zero();
      test_clamp();
      test_loop();
      test_dwell_zero();
      test_clr_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
